// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle MIPS control unit.
// This is one Moore FSM with built-in ALU decode, memory wait-state handshake,
// bne/ori/addi/j support and a sticky illegal-instruction trap.
// Most outputs are registered from the next state. A few outputs are gated
// combinationally in the current cycle:
//   - irwrite and the fetch-time pcen by memready,
//   - the branch pcen by zero,
//   - the write enables and illegal by reset.
module mc_control_fsm #(
   parameter bit MEM_WAIT = 1'b1,
   parameter bit EXT_OPS  = 1'b1
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [5:0] i_op,
   input  logic [5:0] i_funct,
   input  logic       i_zero,
   input  logic       i_memready,
   output logic       o_memwrite,
   output logic       o_iord,
   output logic       o_irwrite,
   output logic       o_regdst,
   output logic       o_memtoreg,
   output logic       o_regwrite,
   output logic       o_alusrca,
   output logic [1:0] o_alusrcb,
   output logic [2:0] o_alucontrol,
   output logic       o_zeroext,
   output logic       o_pcen,
   output logic [1:0] o_pcsrc,
   output logic       o_illegal,
   output logic [3:0] o_state
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMRD    = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWR    = 4'd5,
      S_RTYPEEX  = 4'd6,
      S_RTYPEWB  = 4'd7,
      S_BEQEX    = 4'd8,
      S_ADDIEX   = 4'd9,
      S_IMMWB    = 4'd10,
      S_JEX      = 4'd11,
      S_BNEEX    = 4'd12,
      S_ORIEX    = 4'd13,
      S_ILLEGAL  = 4'd14
   } state_t;

   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   state_t     r_state;
   state_t     w_next;
   state_t     w_tgt;
   logic       w_memready;
   logic       w_funct_ok;
   logic [2:0] w_funct_alu;

   logic       r_memwrite;
   logic       r_iord;
   logic       r_irwrite;
   logic       r_regdst;
   logic       r_memtoreg;
   logic       r_regwrite;
   logic       r_alusrca;
   logic [1:0] r_alusrcb;
   logic [2:0] r_alucontrol;
   logic       r_zeroext;
   logic [1:0] r_pcsrc;
   logic       r_pc_uncond;  // pcen forced high (jump)
   logic       r_pc_mem;     // pcen follows memready (fetch)
   logic       r_pc_zero;    // pcen follows zero (beq)
   logic       r_pc_nzero;   // pcen follows ~zero (bne)
   logic       r_illegal;

   // Without wait states the memory is treated as always ready
   assign w_memready = MEM_WAIT ? i_memready : 1'b1;

   // R-type funct decode: legality and ALU operation
   always_comb begin
      w_funct_ok  = 1'b1;
      w_funct_alu = ALU_ADD;
      case (i_funct)
         6'b100000: w_funct_alu = ALU_ADD;
         6'b100010: w_funct_alu = ALU_SUB;
         6'b100100: w_funct_alu = ALU_AND;
         6'b100101: w_funct_alu = ALU_OR;
         6'b101010: w_funct_alu = ALU_SLT;
         default:   w_funct_ok  = 1'b0;
      endcase
   end

   // Next-state logic; memready matters only in FETCH/MEMRD/MEMWR
   always_comb begin
      w_next = S_FETCH;
      case (r_state)
         S_FETCH:   w_next = w_memready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (i_op)
               OP_LW, OP_SW: w_next = S_MEMADR;
               OP_RTYPE:     w_next = w_funct_ok ? S_RTYPEEX : S_ILLEGAL;
               OP_BEQ:       w_next = S_BEQEX;
               OP_BNE:       w_next = EXT_OPS ? S_BNEEX  : S_ILLEGAL;
               OP_ADDI:      w_next = EXT_OPS ? S_ADDIEX : S_ILLEGAL;
               OP_ORI:       w_next = EXT_OPS ? S_ORIEX  : S_ILLEGAL;
               OP_J:         w_next = EXT_OPS ? S_JEX    : S_ILLEGAL;
               default:      w_next = S_ILLEGAL;
            endcase
         end
         S_MEMADR:  w_next = (i_op == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:   w_next = w_memready ? S_MEMWB : S_MEMRD;
         S_MEMWB:   w_next = S_FETCH;
         S_MEMWR:   w_next = w_memready ? S_FETCH : S_MEMWR;
         S_RTYPEEX: w_next = S_RTYPEWB;
         S_RTYPEWB: w_next = S_FETCH;
         S_BEQEX:   w_next = S_FETCH;
         S_BNEEX:   w_next = S_FETCH;
         S_ADDIEX:  w_next = S_IMMWB;
         S_ORIEX:   w_next = S_IMMWB;
         S_IMMWB:   w_next = S_FETCH;
         S_JEX:     w_next = S_FETCH;
         S_ILLEGAL: w_next = S_ILLEGAL;
         default:   w_next = S_FETCH;
      endcase
   end

   // Reset steers the target state to FETCH so the output registers load FETCH values
   assign w_tgt = i_reset ? S_FETCH : w_next;

   // State register plus Moore outputs registered from the state being entered
   always_ff @(posedge i_clk) begin
      r_state      <= w_tgt;
      r_memwrite   <= 1'b0;
      r_iord       <= 1'b0;
      r_irwrite    <= 1'b0;
      r_regdst     <= 1'b0;
      r_memtoreg   <= 1'b0;
      r_regwrite   <= 1'b0;
      r_alusrca    <= 1'b0;
      r_alusrcb    <= 2'b00;
      r_alucontrol <= ALU_ADD;
      r_zeroext    <= 1'b0;
      r_pcsrc      <= 2'b00;
      r_pc_uncond  <= 1'b0;
      r_pc_mem     <= 1'b0;
      r_pc_zero    <= 1'b0;
      r_pc_nzero   <= 1'b0;
      if (i_reset)
         r_illegal <= 1'b0;
      else if (w_tgt == S_ILLEGAL)
         r_illegal <= 1'b1;
      case (w_tgt)
         S_FETCH: begin
            r_alusrcb <= 2'b01;
            r_irwrite <= 1'b1;
            r_pc_mem  <= 1'b1;
         end
         S_DECODE:  r_alusrcb <= 2'b11;
         S_MEMADR: begin
            r_alusrca <= 1'b1;
            r_alusrcb <= 2'b10;
         end
         S_MEMRD:   r_iord <= 1'b1;
         S_MEMWB: begin
            r_memtoreg <= 1'b1;
            r_regwrite <= 1'b1;
         end
         S_MEMWR: begin
            r_iord     <= 1'b1;
            r_memwrite <= 1'b1;
         end
         S_RTYPEEX: begin
            r_alusrca    <= 1'b1;
            r_alucontrol <= w_funct_alu;
         end
         S_RTYPEWB: begin
            r_regdst   <= 1'b1;
            r_regwrite <= 1'b1;
         end
         S_BEQEX: begin
            r_alusrca    <= 1'b1;
            r_alucontrol <= ALU_SUB;
            r_pcsrc      <= 2'b01;
            r_pc_zero    <= 1'b1;
         end
         S_BNEEX: begin
            r_alusrca    <= 1'b1;
            r_alucontrol <= ALU_SUB;
            r_pcsrc      <= 2'b01;
            r_pc_nzero   <= 1'b1;
         end
         S_ADDIEX: begin
            r_alusrca <= 1'b1;
            r_alusrcb <= 2'b10;
         end
         S_ORIEX: begin
            r_alusrca    <= 1'b1;
            r_alusrcb    <= 2'b10;
            r_alucontrol <= ALU_OR;
            r_zeroext    <= 1'b1;
         end
         S_IMMWB:   r_regwrite <= 1'b1;
         S_JEX: begin
            r_pcsrc     <= 2'b10;
            r_pc_uncond <= 1'b1;
         end
         default: ;
      endcase
   end

   // Input-dependent gating; reset forces every write enable low immediately
   assign o_irwrite    = ~i_reset & r_irwrite & w_memready;
   assign o_pcen       = ~i_reset & (r_pc_uncond | (r_pc_mem & w_memready) |
                                     (r_pc_zero & i_zero) | (r_pc_nzero & ~i_zero));
   assign o_memwrite   = ~i_reset & r_memwrite;
   assign o_regwrite   = ~i_reset & r_regwrite;
   assign o_illegal    = ~i_reset & r_illegal;
   assign o_iord       = r_iord;
   assign o_regdst     = r_regdst;
   assign o_memtoreg   = r_memtoreg;
   assign o_alusrca    = r_alusrca;
   assign o_alusrcb    = r_alusrcb;
   assign o_alucontrol = r_alucontrol;
   assign o_zeroext    = r_zeroext;
   assign o_pcsrc      = r_pcsrc;
   assign o_state      = r_state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm.
// dut is the default build (wait states, extended ops).
// dut2 has MEM_WAIT=0 and EXT_OPS=0 and is checked only in the final segment.
module tb_mc_control_fsm;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       memready;

   logic       memwrite, iord, irwrite, regdst, memtoreg, regwrite, alusrca;
   logic [1:0] alusrcb, pcsrc;
   logic [2:0] alucontrol;
   logic       zeroext, pcen, illegal;
   logic [3:0] state;

   logic       b_memwrite, b_iord, b_irwrite, b_regdst, b_memtoreg, b_regwrite, b_alusrca;
   logic [1:0] b_alusrcb, b_pcsrc;
   logic [2:0] b_alucontrol;
   logic       b_zeroext, b_pcen, b_illegal;
   logic [3:0] b_state;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mc_control_fsm #(.MEM_WAIT(1'b1), .EXT_OPS(1'b1)) dut (
      .i_clk(clk), .i_reset(reset), .i_op(op), .i_funct(funct), .i_zero(zero),
      .i_memready(memready), .o_memwrite(memwrite), .o_iord(iord), .o_irwrite(irwrite),
      .o_regdst(regdst), .o_memtoreg(memtoreg), .o_regwrite(regwrite), .o_alusrca(alusrca),
      .o_alusrcb(alusrcb), .o_alucontrol(alucontrol), .o_zeroext(zeroext), .o_pcen(pcen),
      .o_pcsrc(pcsrc), .o_illegal(illegal), .o_state(state));

   mc_control_fsm #(.MEM_WAIT(1'b0), .EXT_OPS(1'b0)) dut2 (
      .i_clk(clk), .i_reset(reset), .i_op(op), .i_funct(funct), .i_zero(zero),
      .i_memready(memready), .o_memwrite(b_memwrite), .o_iord(b_iord), .o_irwrite(b_irwrite),
      .o_regdst(b_regdst), .o_memtoreg(b_memtoreg), .o_regwrite(b_regwrite),
      .o_alusrca(b_alusrca), .o_alusrcb(b_alusrcb), .o_alucontrol(b_alucontrol),
      .o_zeroext(b_zeroext), .o_pcen(b_pcen), .o_pcsrc(b_pcsrc), .o_illegal(b_illegal),
      .o_state(b_state));

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // advance one rising edge, then let things settle
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; op = 6'b100011; funct = 6'b100000; zero = 1'b0; memready = 1'b1;
      tick();
      // reset held: state FETCH, write enables forced low
      chk("rst_state", state, 4'd0);
      chk("rst_irwrite", irwrite, 4'd0);
      chk("rst_pcen", pcen, 4'd0);
      chk("rst_memwrite", memwrite, 4'd0);
      chk("rst_regwrite", regwrite, 4'd0);
      chk("rst_illegal", illegal, 4'd0);

      // FETCH wait: memready low holds FETCH, no IR/PC update
      reset = 1'b0; memready = 1'b0; #1;
      chk("fw_irwrite", irwrite, 4'd0);
      chk("fw_pcen", pcen, 4'd0);
      tick();
      chk("fw_state", state, 4'd0);

      // lw with memready=1: 0,1,2,3,4,0
      memready = 1'b1; #1;
      chk("lw0_irwrite", irwrite, 4'd1);
      chk("lw0_pcen", pcen, 4'd1);
      chk("lw0_alusrcb", alusrcb, 4'd1);
      chk("lw0_alu", alucontrol, 4'd2);
      tick();
      chk("lw1_state", state, 4'd1);
      chk("lw1_alusrcb", alusrcb, 4'd3);
      chk("lw1_irwrite", irwrite, 4'd0);
      tick();
      chk("lw2_state", state, 4'd2);
      chk("lw2_alusrca", alusrca, 4'd1);
      chk("lw2_alusrcb", alusrcb, 4'd2);
      tick();
      chk("lw3_state", state, 4'd3);
      chk("lw3_iord", iord, 4'd1);
      chk("lw3_regwrite", regwrite, 4'd0);
      tick();
      chk("lw4_state", state, 4'd4);
      chk("lw4_regwrite", regwrite, 4'd1);
      chk("lw4_memtoreg", memtoreg, 4'd1);
      tick();
      chk("lw5_state", state, 4'd0);
      chk("lw5_regwrite", regwrite, 4'd0);

      // sw with three wait cycles in MEMWR
      op = 6'b101011;
      tick(); tick(); tick();
      chk("sw_state_a", state, 4'd5);
      memready = 1'b0; #1;
      chk("sw_mw_a", memwrite, 4'd1);
      chk("sw_iord_a", iord, 4'd1);
      tick();
      chk("sw_state_b", state, 4'd5);
      chk("sw_mw_b", memwrite, 4'd1);
      tick();
      chk("sw_state_c", state, 4'd5);
      chk("sw_mw_c", memwrite, 4'd1);
      tick();
      chk("sw_state_d", state, 4'd5);
      memready = 1'b1; #1;
      chk("sw_mw_d", memwrite, 4'd1);
      tick();
      chk("sw_done", state, 4'd0);
      chk("sw_done_mw", memwrite, 4'd0);

      // reset while waiting in MEMWR aborts the store
      tick(); tick(); tick();
      memready = 1'b0; #1;
      chk("rw_state", state, 4'd5);
      reset = 1'b1; #1;
      chk("rw_memwrite", memwrite, 4'd0);
      tick();
      chk("rw_fetch", state, 4'd0);
      reset = 1'b0; memready = 1'b1;

      // R-type sub: 0,1,6,7,0
      op = 6'b000000; funct = 6'b100010;
      tick(); tick();
      chk("r6_state", state, 4'd6);
      chk("r6_alu", alucontrol, 4'd6);
      chk("r6_alusrca", alusrca, 4'd1);
      chk("r6_alusrcb", alusrcb, 4'd0);
      tick();
      chk("r7_state", state, 4'd7);
      chk("r7_regdst", regdst, 4'd1);
      chk("r7_regwrite", regwrite, 4'd1);
      tick();
      chk("r_done", state, 4'd0);

      // beq taken
      op = 6'b000100; zero = 1'b1;
      tick(); tick();
      chk("beq_state", state, 4'd8);
      chk("beq_pcen", pcen, 4'd1);
      chk("beq_pcsrc", pcsrc, 4'd1);
      chk("beq_alu", alucontrol, 4'd6);
      tick();
      chk("beq_done", state, 4'd0);

      // bne: zero=1 not taken, zero=0 taken
      op = 6'b000101;
      tick(); tick();
      chk("bne_state", state, 4'd12);
      chk("bne_z1_pcen", pcen, 4'd0);
      zero = 1'b0; #1;
      chk("bne_z0_pcen", pcen, 4'd1);
      tick();

      // ori: 13 then 10
      op = 6'b001101;
      tick(); tick();
      chk("ori_state", state, 4'd13);
      chk("ori_alu", alucontrol, 4'd1);
      chk("ori_zeroext", zeroext, 4'd1);
      tick();
      chk("imm_state", state, 4'd10);
      chk("imm_regwrite", regwrite, 4'd1);
      chk("imm_regdst", regdst, 4'd0);
      chk("imm_memtoreg", memtoreg, 4'd0);
      tick();

      // addi: 9 with add, sign extension
      op = 6'b001000;
      tick(); tick();
      chk("addi_state", state, 4'd9);
      chk("addi_alu", alucontrol, 4'd2);
      chk("addi_zeroext", zeroext, 4'd0);
      tick(); tick();

      // j
      op = 6'b000010;
      tick(); tick();
      chk("j_state", state, 4'd11);
      chk("j_pcen", pcen, 4'd1);
      chk("j_pcsrc", pcsrc, 4'd2);
      tick();
      chk("j_done", state, 4'd0);

      // R-type with funct 000000 traps, sticky
      op = 6'b000000; funct = 6'b000000;
      tick(); tick();
      chk("ilr_state", state, 4'd14);
      chk("ilr_illegal", illegal, 4'd1);
      chk("ilr_regwrite", regwrite, 4'd0);
      tick(); tick();
      chk("ilr_hold", state, 4'd14);
      chk("ilr_hold_ill", illegal, 4'd1);
      reset = 1'b1; #1;
      chk("ilr_rst_ill", illegal, 4'd0);
      tick();
      reset = 1'b0;
      chk("ilr_rst_state", state, 4'd0);

      // opcode 111111 traps
      op = 6'b111111;
      tick(); tick();
      chk("ilo_state", state, 4'd14);
      chk("ilo_illegal", illegal, 4'd1);

      // both instances from reset; dut2 ignores memready and rejects j
      reset = 1'b1;
      tick();
      reset = 1'b0; memready = 1'b0; op = 6'b000010; #1;
      chk("nw_state", b_state, 4'd0);
      chk("nw_irwrite", b_irwrite, 4'd1);
      chk("nw_pcen", b_pcen, 4'd1);
      chk("w_irwrite", irwrite, 4'd0);
      tick();
      chk("nw_decode", b_state, 4'd1);
      chk("w_held", state, 4'd0);
      tick();
      chk("noext_j_state", b_state, 4'd14);
      chk("noext_j_ill", b_illegal, 4'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
